// File: rtl/od_line_receiver.sv
// od_line_receiver: receive side of an open-drain single-wire link. It samples the resolved line,
//   decodes pulse-width bits into bytes (LSB first), detects bus resets, and buffers one byte.
// Latency: the line is seen SYNC_STAGES cycles late; a byte or reset indication appears
//   SYNC_STAGES+1 cycles after the line is released.
// Backpressure: one-entry valid/ready buffer. A byte that completes while the buffer is full
//   and not being drained is dropped, and the sticky overrun_o is set.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   line              resolved bus line; only a hard 0 counts as low (1/z/x read as released)
//   data_o, valid_o   buffered byte and its valid flag
//   ready_i           consumer accept
//   rst_det_o         1-cycle pulse on a decoded bus reset
//   frame_err_o       1-cycle pulse when idle timeout aborts a partial byte
//   overrun_o         sticky byte-dropped flag, cleared only by rst_n
//   pd_o              presence pull-down request (only when OD_RX_PRESENCE_EN is defined)
//
// Optional feature macro: OD_RX_PRESENCE_EN (presence pulse after a bus reset).

module od_line_receiver #(
  parameter int SYNC_STAGES  = 2,
  parameter int MIN_LOW      = 2,
  parameter int BIT_THRESH   = 8,
  parameter int RESET_MIN    = 48,
  parameter int IDLE_TIMEOUT = 64,
  parameter int PRESENCE_DLY = 8,
  parameter int PRESENCE_LEN = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       rst_det_o,
  output logic       frame_err_o,
  output logic       overrun_o
`ifdef OD_RX_PRESENCE_EN
  ,
  output logic       pd_o
`endif
);

  // One shared counter serves every state, so size it for the largest limit.
  localparam int MAX_A   = (RESET_MIN + 1 > IDLE_TIMEOUT) ? RESET_MIN + 1 : IDLE_TIMEOUT;
  localparam int MAX_B   = (PRESENCE_DLY > PRESENCE_LEN) ? PRESENCE_DLY : PRESENCE_LEN;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOW       = 3'd1;
  localparam logic [2:0] ST_HIGH      = 3'd2;
`ifdef OD_RX_PRESENCE_EN
  localparam logic [2:0] ST_PRES_WAIT = 3'd3;
  localparam logic [2:0] ST_PRES      = 3'd4;
`endif

  logic [2:0]             state;
  logic [CW-1:0]          cnt;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   line_q;

  logic          line_bit;
  logic          line_s;
  logic          fall;
  logic          rise;
  logic [CW-1:0] width;
  logic          is_glitch;
  logic          is_busrst;
  logic          bit_val;
  logic          bit_ev;
  logic          byte_done;
  logic [7:0]    new_byte;

  // Anything other than a hard 0 is treated as the pulled-up, released line.
  assign line_bit = (line === 1'b0) ? 1'b0 : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      line_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_bit};
      line_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign line_s = sync_q[SYNC_STAGES-1];
  assign fall   = line_q & ~line_s;
  assign rise   = ~line_q & line_s;

  // cnt is cleared on the cycle the low is first seen, so the width including the
  // current (last low) cycle is cnt+1. That makes width equal the raw low duration.
  assign width     = cnt + CW'(1);
  assign is_glitch = (width < CW'(MIN_LOW));
  assign is_busrst = (width >= CW'(RESET_MIN));
  assign bit_val   = (width < CW'(BIT_THRESH));
  assign bit_ev    = (state == ST_LOW) && rise && !is_glitch && !is_busrst;
  assign byte_done = bit_ev && (bitcnt == 3'd7);
  assign new_byte  = {bit_val, shreg[7:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bitcnt      <= 3'd0;
      shreg       <= 8'h00;
      rst_det_o   <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rst_det_o   <= 1'b0;
      frame_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state <= ST_LOW;
            cnt   <= '0;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= '0;
            if (is_busrst) begin
              rst_det_o <= 1'b1;
              bitcnt    <= 3'd0;
              shreg     <= 8'h00;
`ifdef OD_RX_PRESENCE_EN
              state     <= ST_PRES_WAIT;
`endif
            end else if (!is_glitch) begin
              shreg  <= new_byte;
              bitcnt <= bitcnt + 3'd1;  // wraps to 0 on the 8th bit
            end
          end else if (cnt < CW'(RESET_MIN)) begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state <= ST_LOW;
            cnt   <= '0;
          end else if (cnt >= CW'(IDLE_TIMEOUT - 1)) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (bitcnt != 3'd0) begin
              frame_err_o <= 1'b1;
              bitcnt      <= 3'd0;
              shreg       <= 8'h00;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef OD_RX_PRESENCE_EN
        // Our own pull-down shows up on the line, so edges are ignored here.
        ST_PRES_WAIT: begin
          if (cnt >= CW'(PRESENCE_DLY - 1)) begin
            state <= ST_PRES;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PRES: begin
          if (cnt >= CW'(PRESENCE_LEN - 1)) begin
            state <= ST_HIGH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef OD_RX_PRESENCE_EN
  assign pd_o = (state == ST_PRES);
`endif

  // One-entry output buffer. A drain and a load in the same cycle keep valid_o high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o   <= 1'b0;
      data_o    <= 8'h00;
      overrun_o <= 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
      if (byte_done) begin
        if (!valid_o || ready_i) begin
          data_o  <= new_byte;
          valid_o <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_od_line_receiver.sv
module tb_od_line_receiver;

  logic       clk;
  logic       rst_n;
  logic       drv_low;
  logic       ready_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       rst_det_o;
  logic       frame_err_o;
  logic       overrun_o;
`ifdef OD_RX_PRESENCE_EN
  logic       pd_o;
`endif

  // Open-drain line: remote side pulls low or releases; the pull-up resolves release.
  wire bus_line;
  pullup (bus_line);
  assign bus_line = drv_low ? 1'b0 : 1'bz;

  od_line_receiver dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .line        (bus_line),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .rst_det_o   (rst_det_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
`ifdef OD_RX_PRESENCE_EN
    ,
    .pd_o        (pd_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Event monitor sampled on the falling edge, away from the active edge.
  int         cyc      = 0;
  int         hs_cnt   = 0;
  logic [7:0] last_dat = 8'h00;
  int         rd_cnt   = 0;
  int         fe_cnt   = 0;
  int         rd_cyc   = 0;
  int         pd_cnt   = 0;
  int         pd_first = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc = cyc + 1;
      if (valid_o && ready_i) begin
        hs_cnt   = hs_cnt + 1;
        last_dat = data_o;
      end
      if (rst_det_o) begin
        rd_cnt = rd_cnt + 1;
        rd_cyc = cyc;
      end
      if (frame_err_o) fe_cnt = fe_cnt + 1;
`ifdef OD_RX_PRESENCE_EN
      if (pd_o) begin
        if (pd_first < 0) pd_first = cyc;
        pd_cnt = pd_cnt + 1;
      end
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic low_pulse(input int n);
    drv_low = 1'b1;
    step(n);
    drv_low = 1'b0;
  endtask

  // bit 1: 4 low cycles, bit 0: 12 low cycles, followed by `hi` released cycles.
  task automatic send_bit(input logic b, input int hi);
    low_pulse(b ? 4 : 12);
    step(hi);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i], 10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [7:0] pat;
  int         hs0;
  int         fe0;

  initial begin
    rst_n   = 1'b0;
    drv_low = 1'b0;
    ready_i = 1'b1;
    step(3);
    check("rst_valid",   {31'd0, valid_o},     32'd0);
    check("rst_data",    {24'd0, data_o},      32'd0);
    check("rst_rstdet",  {31'd0, rst_det_o},   32'd0);
    check("rst_frerr",   {31'd0, frame_err_o}, 32'd0);
    check("rst_overrun", {31'd0, overrun_o},   32'd0);
`ifdef OD_RX_PRESENCE_EN
    check("rst_pd",      {31'd0, pd_o},        32'd0);
`endif
    rst_n = 1'b1;
    step(5);

    // Byte decode: 0xA5, exact delivery timing after the last release.
    pat = 8'hA5;
    for (int i = 0; i < 7; i++) send_bit(pat[i], 10);
    low_pulse(4);
    step(1);
    check("dec_v_t1", {31'd0, valid_o}, 32'd0);
    step(1);
    check("dec_v_t2", {31'd0, valid_o}, 32'd0);
    step(1);
    check("dec_v_t3", {31'd0, valid_o}, 32'd1);
    check("dec_data", {24'd0, data_o},  32'hA5);
    step(1);
    check("dec_v_t4", {31'd0, valid_o}, 32'd0);
    step(8);
    check("dec_hs",   hs_cnt, 32'd1);

    // Glitch filter: 1-cycle low in the high phase after bit 3.
    for (int i = 0; i < 3; i++) send_bit(pat[i], 10);
    send_bit(pat[3], 4);
    low_pulse(1);
    step(5);
    for (int i = 4; i < 8; i++) send_bit(pat[i], 10);
    check("glitch_hs",   hs_cnt,            32'd2);
    check("glitch_data", {24'd0, last_dat}, 32'hA5);

    // Bus reset after a partial byte; the partial must be discarded.
    for (int i = 0; i < 3; i++) send_bit(1'b1, 10);
    low_pulse(60);
    step(2);
    check("brst_t2", {31'd0, rst_det_o}, 32'd0);
    step(1);
    check("brst_t3", {31'd0, rst_det_o}, 32'd1);
    step(1);
    check("brst_t4", {31'd0, rst_det_o}, 32'd0);
    check("brst_valid", {31'd0, valid_o}, 32'd0);
    step(50);
    check("brst_cnt", rd_cnt, 32'd1);
`ifdef OD_RX_PRESENCE_EN
    check("pres_len", pd_cnt,            32'd24);
    check("pres_dly", pd_first - rd_cyc, 32'd8);
`endif
    send_byte(8'h3C);
    check("brst_next_hs",   hs_cnt,            32'd3);
    check("brst_next_data", {24'd0, last_dat}, 32'h3C);

    // Overrun: 0x11 held, 0x22 dropped, 0x33 loads while the consumer drains.
    ready_i = 1'b0;
    send_byte(8'h11);
    check("ovr_v1",   {31'd0, valid_o},   32'd1);
    check("ovr_d1",   {24'd0, data_o},    32'h11);
    check("ovr_o1",   {31'd0, overrun_o}, 32'd0);
    send_byte(8'h22);
    check("ovr_d2",   {24'd0, data_o},    32'h11);
    check("ovr_o2",   {31'd0, overrun_o}, 32'd1);
    pat = 8'h33;
    for (int i = 0; i < 7; i++) send_bit(pat[i], 10);
    low_pulse(12);
    step(2);
    ready_i = 1'b1;
    step(1);
    check("ovr_v3",   {31'd0, valid_o},   32'd1);
    check("ovr_d3",   {24'd0, data_o},    32'h33);
    step(1);
    check("ovr_drain", {31'd0, valid_o},  32'd0);
    check("ovr_sticky", {31'd0, overrun_o}, 32'd1);
    step(8);

    // Idle timeout: 3 bits then a long release.
    hs0 = hs_cnt;
    fe0 = fe_cnt;
    for (int i = 0; i < 3; i++) send_bit(1'b0, 10);
    step(80);
    check("to_frerr", fe_cnt - fe0, 32'd1);
    check("to_nobyte", hs_cnt - hs0, 32'd0);
    send_byte(8'h5A);
    check("to_next_hs",   hs_cnt - hs0,      32'd1);
    check("to_next_data", {24'd0, last_dat}, 32'h5A);
    check("to_frerr_once", fe_cnt - fe0,     32'd1);

    // Async reset mid-frame with a full buffer and overrun set.
    ready_i = 1'b0;
    send_byte(8'h77);
    check("ar_pre_v", {31'd0, valid_o}, 32'd1);
    check("ar_pre_d", {24'd0, data_o},  32'h77);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid",   {31'd0, valid_o},     32'd0);
    check("ar_data",    {24'd0, data_o},      32'd0);
    check("ar_overrun", {31'd0, overrun_o},   32'd0);
    check("ar_rstdet",  {31'd0, rst_det_o},   32'd0);
    check("ar_frerr",   {31'd0, frame_err_o}, 32'd0);
    step(2);
    rst_n   = 1'b1;
    ready_i = 1'b1;
    step(3);
    hs0 = hs_cnt;
    send_byte(8'hC3);
    check("ar_next_hs",   hs_cnt - hs0,      32'd1);
    check("ar_next_data", {24'd0, last_dat}, 32'hC3);
    check("ar_next_ovr",  {31'd0, overrun_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
